// File: rtl/core_ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, NOP encoding,
// PC step, default reset PC and the buffer entry layout.
package core_ifetch_pkg;

    localparam int unsigned InstAddressBus = 32;
    localparam int unsigned InstByteBus    = 32;
    localparam int unsigned InstByteWidth  = 32;

    localparam logic [InstAddressBus-1:0] PcIncr   = InstAddressBus'(InstByteWidth / 8);
    localparam logic [InstAddressBus-1:0] ResetPC  = 32'h0000_0000;
    localparam logic [InstByteBus-1:0]    INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [InstAddressBus-1:0] addr;
        logic [InstByteBus-1:0]    data;
        logic                      filled;
    } if_entry_t;

    function automatic logic [InstAddressBus-1:0] align_pc(input logic [InstAddressBus-1:0] a);
        return {a[InstAddressBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_ifetch_buf.sv
// In-order fetch entry buffer: allocation/fill/read pointers, occupancy
// counters and the count of in-flight responses to be discarded.
module core_if_buf
    import core_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = ResetPC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc,
    input  logic [InstAddressBus-1:0]          alloc_addr,
    input  logic                               rsp_valid,
    input  logic [InstByteBus-1:0]             rsp_data,
    input  logic                               rsp_bypass,
    input  logic                               pop,
    input  logic                               flush,
    output logic                               head_filled,
    output logic [InstAddressBus-1:0]          head_addr,
    output logic [InstByteBus-1:0]             head_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     alloc_cnt,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     drop_cnt
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    if_entry_t       ent [BUF_DEPTH];
    logic [PW-1:0]   alloc_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]   unfilled_cnt;
    logic            rsp_take;

    assign rsp_take    = rsp_valid && (drop_cnt == '0);
    assign head_filled = ent[rd_ptr].filled;
    assign head_addr   = ent[rd_ptr].addr;
    assign head_data   = ent[rd_ptr].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                ent[PW'(i)] <= '{addr: RESET_PC, data: INST_NOP, filled: 1'b0};
            end
        end else if (flush) begin
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            // every unfilled entry still has a response on its way; the one arriving now is already gone
            drop_cnt     <= drop_cnt + unfilled_cnt - CW'(rsp_valid);
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                ent[PW'(i)].filled <= 1'b0;
            end
        end else begin
            if (rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (rsp_take) begin
                ent[fill_ptr].data   <= rsp_data;
                ent[fill_ptr].filled <= !rsp_bypass;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            if (pop) begin
                ent[rd_ptr].filled <= 1'b0;
                rd_ptr             <= rd_ptr + 1'b1;
            end
            if (alloc) begin
                ent[alloc_ptr].addr   <= alloc_addr;
                ent[alloc_ptr].filled <= 1'b0;
                alloc_ptr             <= alloc_ptr + 1'b1;
            end
            alloc_cnt    <= alloc_cnt + CW'(alloc) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(rsp_take);
        end
    end

endmodule

// File: rtl/core_ifetch.sv
// Instruction fetch stage: PC, request gating, redirect handling.
// Define IF_BYPASS_EN to forward a head response straight to decode in the same cycle.
module core_ifetch
    import core_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = ResetPC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_valid_out,
    input  logic                      imem_req_ready_in,
    output logic [InstAddressBus-1:0] imem_req_addr_out,
    input  logic                      imem_rsp_valid_in,
    input  logic [InstByteBus-1:0]    imem_rsp_data_in,
    input  logic                      jump_en_in,
    input  logic [InstAddressBus-1:0] jump_addr_in,
    output logic                      inst_valid_out,
    input  logic                      inst_ready_in,
    output logic [InstByteBus-1:0]    inst_out,
    output logic [InstAddressBus-1:0] inst_addr_out
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [InstAddressBus-1:0] pc_q;
    logic [CW-1:0]             alloc_cnt, drop_cnt;
    logic                      head_filled;
    logic [InstAddressBus-1:0] head_addr;
    logic [InstByteBus-1:0]    head_data;
    logic                      accept, pop, bypass;

    // held low while reset is asserted so the interface is quiet during reset
    assign imem_req_valid_out = rst && !jump_en_in
                                && (({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr_out  = pc_q;
    assign accept             = imem_req_valid_out && imem_req_ready_in;

`ifdef IF_BYPASS_EN
    assign bypass = !head_filled && (drop_cnt == '0) && imem_rsp_valid_in && !jump_en_in;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid_out = (head_filled || bypass) && !jump_en_in;
    assign inst_out       = !inst_valid_out ? INST_NOP :
                            head_filled     ? head_data : imem_rsp_data_in;
    assign inst_addr_out  = head_addr;
    assign pop            = inst_valid_out && inst_ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (jump_en_in) begin
            pc_q <= align_pc(jump_addr_in);
        end else if (accept) begin
            pc_q <= pc_q + PcIncr;
        end
    end

    core_if_buf #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .alloc       (accept),
        .alloc_addr  (pc_q),
        .rsp_valid   (imem_rsp_valid_in),
        .rsp_data    (imem_rsp_data_in),
        .rsp_bypass  (bypass && inst_ready_in),
        .pop         (pop),
        .flush       (jump_en_in),
        .head_filled (head_filled),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .alloc_cnt   (alloc_cnt),
        .drop_cnt    (drop_cnt)
    );

endmodule

// File: tb/tb_core_ifetch.sv
// Bench for core_ifetch: queue-based fetch model plus an in-order memory responder.
module tb_core_ifetch;
    import core_ifetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk, rst;
    logic        imem_req_valid_out, imem_req_ready_in;
    logic [31:0] imem_req_addr_out;
    logic        imem_rsp_valid_in;
    logic [31:0] imem_rsp_data_in;
    logic        jump_en_in;
    logic [31:0] jump_addr_in;
    logic        inst_valid_out, inst_ready_in;
    logic [31:0] inst_out, inst_addr_out;

    core_ifetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_req_addr_out  (imem_req_addr_out),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .jump_en_in         (jump_en_in),
        .jump_addr_in       (jump_addr_in),
        .inst_valid_out     (inst_valid_out),
        .inst_ready_in      (inst_ready_in),
        .inst_out           (inst_out),
        .inst_addr_out      (inst_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; bit filled; } ment_t;
    typedef struct { logic [31:0] data; int unsigned due; } mrsp_t;

    ment_t       q[$];      // fetched-but-not-decoded instructions, program order
    mrsp_t       pend[$];   // memory responses not yet returned, in order
    int          m_drop;
    logic [31:0] m_pc;
    int unsigned cyc;
    int unsigned ready_pct, irdy_pct, rsp_pct, lat_max;
    int unsigned vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; jump_en_in = 1'b0; jump_addr_in = '0;
        imem_req_ready_in = 1'b1; inst_ready_in = 1'b1;
        imem_rsp_valid_in = 1'b0; imem_rsp_data_in = '0;
        q.delete(); pend.delete(); m_drop = 0; m_pc = RPC;
        #1;
        chk("rst_req_valid",  {31'b0, imem_req_valid_out}, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid_out},     32'h0);
        chk("rst_inst",       inst_out,                    INST_NOP);
        chk("rst_inst_addr",  inst_addr_out,               RPC);
        @(negedge clk);
    endtask

    // one clock: drive inputs at negedge, check outputs 1ns later, advance the model
    task automatic step(input bit jmp, input logic [31:0] jaddr);
        bit          rv, exp_rv, hf, byp, exp_iv;
        logic [31:0] exp_inst;
        int          unf;
        @(negedge clk);
        rst = 1'b1;
        jump_en_in        = jmp;
        jump_addr_in      = jaddr;
        imem_req_ready_in = ($urandom_range(99) < ready_pct);
        inst_ready_in     = ($urandom_range(99) < irdy_pct);
        rv = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid_in = rv;
        imem_rsp_data_in  = rv ? pend[0].data : $urandom;
        #1;
        unf = 0;
        foreach (q[i]) if (!q[i].filled) unf++;
        exp_rv = !jmp && ((q.size() + m_drop) < int'(DEPTH));
        hf     = (q.size() > 0) && q[0].filled;
`ifdef IF_BYPASS_EN
        byp = !hf && (m_drop == 0) && rv && !jmp;
`else
        byp = 1'b0;
`endif
        exp_iv   = (hf || byp) && !jmp;
        exp_inst = !exp_iv ? INST_NOP : (hf ? q[0].data : imem_rsp_data_in);

        chk("req_valid",  {31'b0, imem_req_valid_out}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr_out, m_pc);
        chk("inst_valid", {31'b0, inst_valid_out}, {31'b0, exp_iv});
        chk("inst",       inst_out, exp_inst);
        if (exp_iv) chk("inst_addr", inst_addr_out, q[0].addr);

        if (rv) void'(pend.pop_front());
        if (jmp) begin
            m_drop = m_drop + unf - int'(rv);
            q.delete();
            m_pc = {jaddr[31:2], 2'b00};
        end else begin
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else if (!(byp && inst_ready_in)) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (!q[i].filled) begin
                            q[i].data = imem_rsp_data_in;
                            q[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (exp_iv && inst_ready_in) void'(q.pop_front());
            if (exp_rv && imem_req_ready_in) begin
                q.push_back('{addr: m_pc, data: 32'h0, filled: 1'b0});
                pend.push_back('{data: $urandom, due: cyc + $urandom_range(lat_max, 1)});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        bit          j;
        logic [31:0] ja;
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b0; jump_en_in = 1'b0; jump_addr_in = '0;
        imem_req_ready_in = 1'b0; inst_ready_in = 1'b0;
        imem_rsp_valid_in = 1'b0; imem_rsp_data_in = '0;
        ready_pct = 100; irdy_pct = 100; rsp_pct = 100; lat_max = 1;
        do_reset();

        // streaming from reset, memory always ready, 1-cycle responses
        repeat (10) step(1'b0, '0);
        // decode stalled: fetch must stop once the buffer is committed
        irdy_pct = 0;
        repeat (6) step(1'b0, '0);
        irdy_pct = 100;
        repeat (6) step(1'b0, '0);

        // redirect with requests in flight
        rsp_pct = 0;
        repeat (3) step(1'b0, '0);
        step(1'b1, 32'h0000_0103);
        rsp_pct = 100;
        repeat (8) step(1'b0, '0);

        // redirect coinciding with a response and a decode handshake
        irdy_pct = 0; rsp_pct = 0;
        repeat (2) step(1'b0, '0);
        rsp_pct = 100;
        step(1'b0, '0);
        irdy_pct = 100;
        step(1'b1, 32'h0000_0100);
        repeat (8) step(1'b0, '0);

        // PC wrap and back-to-back redirects
        step(1'b1, 32'hFFFF_FFFC);
        repeat (6) step(1'b0, '0);
        rsp_pct = 0;
        repeat (2) step(1'b0, '0);
        step(1'b1, 32'h0000_2000);
        step(1'b1, 32'h0000_3002);
        rsp_pct = 100;
        repeat (8) step(1'b0, '0);

        // randomized traffic
        ready_pct = 70; irdy_pct = 70; rsp_pct = 60; lat_max = 4;
        repeat (3000) begin
            j  = ($urandom_range(99) < 4);
            ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(j, ja);
        end

        // reset in the middle of traffic, then resume
        do_reset();
        repeat (300) begin
            j  = ($urandom_range(99) < 4);
            ja = $urandom;
            step(j, ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
